// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit BHT lookup in IF, prediction tracking F->M, resolve and train in MEM.
module branch_predictor #(
   parameter int DATA_WIDTH = 32,
   parameter int INDEX_BITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] pc,
   input  logic [DATA_WIDTH-1:0] instr_F,
   input  logic [DATA_WIDTH-1:0] pc_M,
   input  logic [7:0]            branch_M,
   input  logic                  pcsrc,
   input  logic                  load_use_flag,
   output logic                  pre_branch,
   output logic                  prediction,
   output logic [DATA_WIDTH-1:0] label,
   output logic                  correct,
   output logic                  error,
   output logic [DATA_WIDTH-1:0] new_label
);
   localparam int ENTRIES = 1 << INDEX_BITS;
   logic [1:0]            bht [ENTRIES];
   logic                  is_b, is_jal, pt_d, pt_e, pt_m, flush, upd;
   logic [DATA_WIDTH-1:0] b_imm, j_imm;
   logic [INDEX_BITS-1:0] idx_f, idx_m;
   logic [1:0]            cnt_m, cnt_nxt;
   logic                  unused_jumps;
   assign unused_jumps = ^branch_M[7:6];
   assign is_b       = instr_F[6:0] == 7'b1100011;
   assign is_jal     = instr_F[6:0] == 7'b1101111;
   assign pre_branch = is_b | is_jal;
   assign b_imm = {{(DATA_WIDTH-12){instr_F[31]}}, instr_F[7], instr_F[30:25], instr_F[11:8], 1'b0};
   assign j_imm = {{(DATA_WIDTH-20){instr_F[31]}}, instr_F[19:12], instr_F[20], instr_F[30:21], 1'b0};
   assign label = is_jal ? pc + j_imm : is_b ? pc + b_imm : '0;
   assign idx_f      = pc[INDEX_BITS+1:2];
   assign idx_m      = pc_M[INDEX_BITS+1:2];
   assign prediction = pre_branch & (is_jal | bht[idx_f][1]);
   assign correct   = pt_m & pcsrc;
   assign error     = pt_m & ~pcsrc;
   assign new_label = pc_M + DATA_WIDTH'(4);
   // taken-but-unpredicted is also a redirect, so it must squash younger predictions
   assign flush = (pcsrc & ~correct) | error;
   assign upd   = |branch_M[5:0];
   assign cnt_m = bht[idx_m];
   always_comb begin
      cnt_nxt = cnt_m;
      if (pcsrc && cnt_m != 2'd3) cnt_nxt = cnt_m + 2'd1;
      else if (!pcsrc && cnt_m != 2'd0) cnt_nxt = cnt_m - 2'd1;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
         pt_d <= 1'b0;
         pt_e <= 1'b0;
         pt_m <= 1'b0;
      end else begin
         if (upd) bht[idx_m] <= cnt_nxt;
         pt_d <= flush ? 1'b0 : load_use_flag ? pt_d : prediction & pre_branch;
         pt_e <= (flush | load_use_flag) ? 1'b0 : pt_d;
         pt_m <= flush ? 1'b0 : pt_e;
      end
   end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor and resolver for the 5-stage RISC-V pipeline. It is the counterpart of the datapath's prediction interface. In IF it tells the datapath whether the fetched instruction is a predictable branch/jump, whether to take it, and the target. In MEM it compares the carried prediction with the resolved outcome and drives `correct`, `error` and `new_label`. It holds a PC-indexed table of 2-bit saturating counters and carries prediction state F→D→E→M in lockstep with the datapath pipeline registers.

## Interface
Parameters:
- `DATA_WIDTH`, 32: PC/instruction width.
- `INDEX_BITS`, 4: BHT index width; the table has 2^INDEX_BITS entries, indexed by `pc[INDEX_BITS+1:2]`.

Ports:
- `clk` in 1: clock. Rising edge.
- `rst` in 1: reset. Asynchronous, active-low. Single clock domain.
- `pc` in DATA_WIDTH: IF-stage PC.
- `instr_F` in DATA_WIDTH: instruction fetched at `pc`.
- `pc_M` in DATA_WIDTH: MEM-stage PC.
- `branch_M` in 8: MEM-stage branch one-hot. Bits [5:0] are conditional branches, [6] is JAL, [7] is JALR.
- `pcsrc` in 1: MEM-stage resolved taken.
- `load_use_flag` in 1: load-use stall.
- `pre_branch` out 1: IF instruction is B-type (opcode 1100011) or JAL (1101111).
- `prediction` out 1: predict taken.
- `label` out DATA_WIDTH: predicted target.
- `correct` out 1: MEM branch was predicted taken and resolved taken.
- `error` out 1: MEM branch was predicted taken and resolved not-taken.
- `new_label` out DATA_WIDTH: recovery PC, `pc_M + 4`.

## Operation
- IF lookup (combinational):
  - `pre_branch` = opcode is B or JAL. JALR is never predicted, so `pre_branch` = 0 for it.
  - `label` = `pc` + imm, modulo 2^DATA_WIDTH. B-imm = sign-extended {i[31], i[7], i[30:25], i[11:8], 0}. J-imm = sign-extended {i[31], i[19:12], i[20], i[30:21], 0}. Valid only when `pre_branch` = 1; otherwise 0.
  - `prediction` = `pre_branch` & (JAL | BHT[idx][1]).
- Pipeline tracking: 1-bit registers `pt_D`, `pt_E`, `pt_M` carry `prediction & pre_branch`.
  - flush = (`pcsrc` & ~`correct`) | `error`.
  - `pt_D`: cleared on flush, else held on `load_use_flag`, else loads. Flush beats stall.
  - `pt_E`: cleared on flush or `load_use_flag`, else loads `pt_D`.
  - `pt_M`: cleared on flush, else loads `pt_E`.
- MEM resolve (combinational):
  - `correct` = `pt_M` & `pcsrc`.
  - `error` = `pt_M` & ~`pcsrc`.
  - `new_label` = `pc_M + 4`, always driven.
  - Mispredicted not-taken (`pcsrc` & ~`pt_M`) is recovered by the datapath itself; both `correct` and `error` are 0 in that case.
  - Target mismatch is impossible, because B and JAL targets are computed statically.
- BHT update, on the clock edge ending the MEM cycle, when |`branch_M[5:0]`:
  - Counter at `pc_M[INDEX_BITS+1:2]` increments if `pcsrc`, else decrements.
  - Saturates at 3 and at 0.
  - JAL and JALR never update the BHT.
- Same-cycle update and lookup of the same index: lookup returns the pre-update value. No bypass.

## Timing
- Lookup outputs: zero-latency combinational from `pc`, `instr_F` and BHT state.
- Resolve outputs: combinational from `pt_M`, `pcsrc` and `pc_M`.
- Prediction to resolution: 3 clock edges with no stalls, plus 1 per `load_use_flag` cycle while the branch sits in D.
- BHT write becomes visible to lookup on the cycle after the MEM cycle.
- Reset (asynchronous assert, any time including mid-operation):
  - All BHT entries become 2'b01 (weakly not-taken).
  - `pt_D`, `pt_E`, `pt_M` become 0.
  - As a result `correct` = `error` = 0 immediately.
  - `pre_branch`, `prediction` and `label` follow their inputs. With `instr_F` = 0 they are all 0.

## Test plan
1. **Reset:** hold `rst`=0, apply beq at `pc`=0x10 with imm=+8 → `pre_branch`=1, `prediction`=0, `label`=0x18, `correct`=`error`=0.
2. **Training:** resolve beq at `pc_M`=0x20 taken (`branch_M`=8'h01, `pcsrc`=1) on 2 separate cycles → counter goes 01→10→11. Next fetch of 0x20 gives `prediction`=1.
3. **Predicted taken, resolved not-taken:**
   - Setup: trained beq at 0x20, no stalls.
   - 3 cycles after fetch: `pcsrc`=0 → `error`=1, `new_label`=0x24, `correct`=0.
   - Counter 11→10.
   - `pt_D`/`pt_E`/`pt_M` are 0 on the next cycle.
4. **JAL:**
   - Fetch JAL at 0x40 with imm=0x100 → `pre_branch`=1, `prediction`=1, `label`=0x140.
   - At MEM with `branch_M`=8'h40, `pcsrc`=1 → `correct`=1, `error`=0.
   - BHT unchanged.
5. **Stall:**
   - Setup: predicted-taken branch in D with `load_use_flag`=1 for one cycle.
   - `pt_D` holds and `pt_E` becomes 0 for one cycle.
   - The prediction reaches M 4 edges after fetch and `correct`=1 when `pcsrc`=1.
6. **Boundary cases:**
   - beq at 0xFFFFFFFC with imm=+8 → `label`=0x00000004 (wrap).
   - Update and lookup of the same index in one cycle → lookup returns the old counter.
   - Assert `rst` mid-flight with `pt_M`=1 → `correct`/`error` drop to 0 immediately and all counters read 01.
